// File: rtl/reverse_sched_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : reverse_sched_if
// Brief    : Valid/ready beat stream (master drives val/dat, slave drives rdy)
// Revision : 1.0
// ============================================================================
interface reverse_sched_if #(
    parameter int DW = 512
);
    logic          val;
    logic          rdy;
    logic [DW-1:0] dat;

    modport master (output val, output dat, input rdy);
    modport slave  (input val, input dat, output rdy);
endinterface
`default_nettype wire

// File: rtl/reverse_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : reverse_sched
// Brief    : Feeds source beats to a byte-reversal engine in 128-bit slices and
//            reassembles its byte stream into result beats.
//            Optional busy-cycle counter: REVERSE_SCHED_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module reverse_sched #(
    parameter int AXI_DW = 512,
    parameter int NUM_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_start_i,
    input  logic [NUM_W-1:0]  cfg_num_i,
    output logic              cfg_busy_o,
    output logic              cfg_done_o,
    reverse_sched_if.slave    in_s,
    reverse_sched_if.master   out_m,
    output logic              eng_start_o,
    input  logic              eng_rden_i,
    output logic [127:0]      eng_data_o,
    input  logic              eng_bs_val_i,
    input  logic [7:0]        eng_bs_dat_i,
    input  logic              eng_done_i,
    output logic [31:0]       perf_cyc_o
);
    // Slice and byte indices wrap naturally; AXI_DW must be a power-of-two multiple of 256.
    localparam int C_NSL = AXI_DW / 128;
    localparam int C_SLW = $clog2(C_NSL);
    localparam int C_BW  = $clog2(AXI_DW / 8);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_PUSH  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             r_state;
    logic [NUM_W-1:0]   r_rem;
    logic [C_SLW-1:0]   r_sl;
    logic [C_BW-1:0]    r_bi;
    logic [AXI_DW-1:0]  r_in_buf;
    logic [AXI_DW-1:0]  r_out_buf;
    logic               r_busy;
    logic               r_done;
    logic               r_in_rdy;
    logic               r_out_val;
    logic               r_eng_start;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_sl        <= '0;
            r_bi        <= '0;
            r_in_buf    <= '0;
            r_out_buf   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_rdy    <= 1'b0;
            r_out_val   <= 1'b0;
            r_eng_start <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Busy covers the done cycle; an accept in that same cycle re-arms it below.
            if (r_done) begin
                r_busy <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (cfg_start_i) begin
                        r_rem    <= cfg_num_i;
                        r_busy   <= 1'b1;
                        r_in_rdy <= (cfg_num_i != '0);
                        r_state  <= (cfg_num_i == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Cleared here so a short engine byte count leaves zeros behind.
                    r_out_buf <= '0;
                    if (in_s.val) begin
                        r_in_buf    <= in_s.dat;
                        r_sl        <= '0;
                        r_bi        <= '0;
                        r_in_rdy    <= 1'b0;
                        r_eng_start <= 1'b1;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    r_eng_start <= 1'b0;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    if (eng_rden_i) begin
                        r_sl <= r_sl + 1'b1;
                    end
                    if (eng_bs_val_i) begin
                        r_out_buf[8*r_bi +: 8] <= eng_bs_dat_i;
                        r_bi                   <= r_bi + 1'b1;
                    end
                    if (eng_done_i) begin
                        r_out_val <= 1'b1;
                        r_state   <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (out_m.rdy) begin
                        r_out_val <= 1'b0;
                        r_rem     <= r_rem - 1'b1;
                        if (r_rem == NUM_W'(1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_in_rdy <= 1'b1;
                            r_state  <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_busy_o  = r_busy;
    assign cfg_done_o  = r_done;
    assign in_s.rdy    = r_in_rdy;
    assign out_m.val   = r_out_val;
    assign out_m.dat   = r_out_buf;
    assign eng_start_o = r_eng_start;
    assign eng_data_o  = r_in_buf[128*r_sl +: 128];

`ifdef REVERSE_SCHED_PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf <= 32'd0;
        end else if (r_state == S_IDLE && cfg_start_i) begin
            r_perf <= 32'd0;
        end else if (r_busy && r_perf != 32'hFFFF_FFFF) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cyc_o = r_perf;
`else
    assign perf_cyc_o = 32'd0;
`endif

endmodule
`default_nettype wire
